// File: rtl/dm_sba_responder.sv
// Device-end responder for the DM system bus access host port.
// Word-addressed scratch memory behind a req/gnt/r_valid handshake, with a
// programmable grant stall after each transfer and a fixed-latency response
// pipeline that never backpressures.
module dm_sba_responder #(
  parameter int unsigned          BusWidth    = 32,
  parameter int unsigned          MemWords    = 256,
  parameter logic [BusWidth-1:0]  BaseAddr    = 32'h8000_0000,
  parameter int unsigned          RespLatency = 1,
  parameter int unsigned          StallCycles = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic [BusWidth-1:0]     add_i,
  input  logic                    we_i,
  input  logic [BusWidth-1:0]     wdata_i,
  input  logic [BusWidth/8-1:0]   be_i,
  output logic                    gnt_o,
  output logic                    r_valid_o,
  output logic [BusWidth-1:0]     r_rdata_o,
  output logic                    r_err_o,
  output logic [7:0]              err_cnt_o
);

  localparam int unsigned     NumBytes = BusWidth / 8;
  localparam int unsigned     OffW     = $clog2(NumBytes);
  localparam int unsigned     IdxW     = $clog2(MemWords);
  localparam longint unsigned Span     = 64'(MemWords) * 64'(NumBytes);
  localparam logic [3:0]      StallLd  = 4'(StallCycles);

  // Parameter sanity, caught at elaboration
  if (RespLatency < 1 || RespLatency > 4) begin : g_bad_lat
    $error("RespLatency must be 1..4");
  end
  if (StallCycles > 15) begin : g_bad_stall
    $error("StallCycles must be 0..15");
  end
  if (MemWords == 0 || (MemWords & (MemWords - 1)) != 0) begin : g_bad_words
    $error("MemWords must be a power of two");
  end
  if ((64'(BaseAddr) % Span) != 0) begin : g_bad_base
    $error("BaseAddr must be aligned to the window size");
  end

  logic [3:0]                          stall_cnt;
  logic [MemWords-1:0][BusWidth-1:0]   mem;
  logic [RespLatency-1:0]              vld_pipe;
  logic [RespLatency-1:0]              err_pipe;
  logic [RespLatency-1:0][BusWidth-1:0] dat_pipe;

  logic                xfer;
  logic                in_range;
  logic [BusWidth-1:0] off;
  logic [IdxW-1:0]     idx;

  // Grant comes purely from the stall counter so it never combinationally
  // depends on req_i.
  assign gnt_o = (stall_cnt == 4'd0);
  assign xfer  = req_i & gnt_o;

  // Decode: the lower-bound compare guards against the subtraction wrapping,
  // the 64-bit upper-bound compare lets the window touch the top of memory.
  assign off      = add_i - BaseAddr;
  assign in_range = (add_i >= BaseAddr) && (64'(off) < Span);
  assign idx      = off[OffW +: IdxW];

  // Stall counter: reload after each transfer, count down to zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       stall_cnt <= 4'd0;
    else if (xfer)     stall_cnt <= StallLd;
    else if (gnt_o == 1'b0) stall_cnt <= stall_cnt - 4'd1;
  end

  // Backing store: per-byte-lane write; out-of-range writes are dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem <= '0;
    end else if (xfer && we_i && in_range) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Response pipeline: stage 0 captures the read word pre-write, then shifts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= xfer;
      err_pipe[0] <= xfer & ~in_range;
      dat_pipe[0] <= (xfer && !we_i && in_range) ? mem[idx] : '0;
      for (int i = 1; i < RespLatency; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        err_pipe[i] <= err_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign r_valid_o = vld_pipe[RespLatency-1];
  assign r_err_o   = err_pipe[RespLatency-1];
  assign r_rdata_o = dat_pipe[RespLatency-1];

  // Saturating count of error responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                       err_cnt_o <= 8'd0;
    else if (r_valid_o && r_err_o && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
  end

endmodule

// File: tb/tb_dm_sba_responder.sv
// Bench for dm_sba_responder: three instances with different latency/stall
// settings share one stimulus stream; a time-slot scoreboard model predicts
// every output of every instance each cycle.
module tb_dm_sba_responder;

  localparam int          ND   = 3;
  localparam int          LAT [ND] = '{1, 3, 1};
  localparam int          STL [ND] = '{0, 0, 3};
  localparam longint unsigned BASE = 64'h8000_0000;
  localparam longint unsigned SPAN = 64'd1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] add;
  logic        we;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        gnt [ND];
  logic        rv  [ND];
  logic        re  [ND];
  logic [31:0] rd  [ND];
  logic [7:0]  ec  [ND];

  always #5 clk = ~clk;

  dm_sba_responder #(.RespLatency(1), .StallCycles(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .we_i(we),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt[0]), .r_valid_o(rv[0]),
    .r_rdata_o(rd[0]), .r_err_o(re[0]), .err_cnt_o(ec[0]));

  dm_sba_responder #(.RespLatency(3), .StallCycles(0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .we_i(we),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt[1]), .r_valid_o(rv[1]),
    .r_rdata_o(rd[1]), .r_err_o(re[1]), .err_cnt_o(ec[1]));

  dm_sba_responder #(.RespLatency(1), .StallCycles(3)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .we_i(we),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt[2]), .r_valid_o(rv[2]),
    .r_rdata_o(rd[2]), .r_err_o(re[2]), .err_cnt_o(ec[2]));

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: memory image, grant wait count, and responses scheduled
  // into time slots (slot = cycle the response becomes visible).
  logic [31:0] mmem [ND][256];
  int          m_wait [ND];
  bit          m_v [ND];
  bit          m_e [ND];
  logic [31:0] m_d [ND];
  int          m_cnt [ND];
  bit          s_v [ND][8];
  bit          s_e [ND][8];
  logic [31:0] s_d [ND][8];
  int          cyc = 0;

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int w = 0; w < 256; w++) mmem[d][w] = 32'd0;
      m_wait[d] = 0; m_v[d] = 0; m_e[d] = 0; m_d[d] = 32'd0; m_cnt[d] = 0;
      for (int s = 0; s < 8; s++) begin s_v[d][s] = 0; s_e[d][s] = 0; s_d[d][s] = 32'd0; end
    end
  endtask

  // Advance the model across one clock edge using the inputs now applied
  task automatic model_step();
    longint unsigned a;
    bit inr, x;
    int w, slot;
    a   = 64'(add);
    inr = (a >= BASE) && (a < BASE + SPAN);
    w   = inr ? int'((a - BASE) / 4) : 0;
    for (int d = 0; d < ND; d++) begin
      x = req && (m_wait[d] == 0);
      if (m_v[d] && m_e[d] && m_cnt[d] < 255) m_cnt[d]++;
      if (x) begin
        slot = (cyc + LAT[d]) % 8;
        s_v[d][slot] = 1;
        s_e[d][slot] = !inr;
        s_d[d][slot] = (!we && inr) ? mmem[d][w] : 32'd0;
        if (we && inr)
          for (int k = 0; k < 4; k++)
            if (be[k]) mmem[d][w][8*k +: 8] = wdata[8*k +: 8];
        m_wait[d] = STL[d];
      end else if (m_wait[d] > 0) begin
        m_wait[d]--;
      end
    end
    cyc++;
    for (int d = 0; d < ND; d++) begin
      slot = cyc % 8;
      m_v[d] = s_v[d][slot]; m_e[d] = s_e[d][slot]; m_d[d] = s_d[d][slot];
      s_v[d][slot] = 0; s_e[d][slot] = 0; s_d[d][slot] = 32'd0;
    end
  endtask

  task automatic check_outs();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d_gnt", d),   32'(gnt[d]), 32'(m_wait[d] == 0));
      chk($sformatf("d%0d_valid", d), 32'(rv[d]),  32'(m_v[d]));
      chk($sformatf("d%0d_err", d),   32'(re[d]),  32'(m_e[d]));
      chk($sformatf("d%0d_rdata", d), rd[d],       m_d[d]);
      chk($sformatf("d%0d_errcnt", d), 32'(ec[d]), 32'(m_cnt[d]));
    end
  endtask

  task automatic drive(input bit r, input logic [31:0] a, input bit w,
                       input logic [31:0] d, input logic [3:0] b);
    req = r; add = a; we = w; wdata = d; be = b;
  endtask

  task automatic idle();
    drive(0, 32'd0, 0, 32'd0, 4'd0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  // Asynchronous reset asserted mid-cycle, released mid-cycle
  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    #1;
    check_outs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    check_outs();
    do_reset();

    // Write then read back at default latency
    drive(1, 32'h8000_0010, 1, 32'hDEAD_BEEF, 4'hF); tick();
    drive(1, 32'h8000_0010, 0, 32'd0, 4'h0);         tick();
    chk("t1_valid", 32'(rv[0]), 32'd1);
    chk("t1_rdata", rd[0], 32'hDEAD_BEEF);
    chk("t1_err",   32'(re[0]), 32'd0);
    idle(); tick();

    // Byte-enable merge
    drive(1, 32'h8000_0020, 1, 32'h1122_3344, 4'hF); tick();
    drive(1, 32'h8000_0020, 1, 32'hAABB_CCDD, 4'h5); tick();
    drive(1, 32'h8000_0020, 0, 32'd0, 4'h0);         tick();
    chk("t2_rdata", rd[0], 32'h11BB_33DD);
    idle(); tick();

    // Out-of-range read and write
    do_reset();
    drive(1, 32'h7FFF_FFFC, 0, 32'd0, 4'h0);         tick();
    chk("t3_rd_err",  32'(re[0]), 32'd1);
    chk("t3_rd_data", rd[0], 32'd0);
    drive(1, 32'h8000_0400, 1, 32'hFFFF_FFFF, 4'hF); tick();
    chk("t3_wr_err",  32'(re[0]), 32'd1);
    idle(); tick();
    chk("t3_errcnt",  32'(ec[0]), 32'd2);
    drive(1, 32'h8000_0000, 0, 32'd0, 4'h0);         tick();
    chk("t3_word0",   rd[0], 32'd0);
    idle(); tick();

    // Grant stall pattern with req held
    do_reset();
    drive(1, 32'h8000_0010, 0, 32'd0, 4'h0);
    for (int i = 0; i < 9; i++) begin
      chk("t4_gnt", 32'(gnt[2]), 32'(i % 4 == 0));
      tick();
    end
    idle(); tick(); tick();

    // Back-to-back reads through the 3-deep pipeline
    do_reset();
    for (int j = 0; j < 4; j++) begin
      drive(1, 32'h8000_0000 + 32'(j) * 4, 1, 32'hA500_0000 + 32'(j), 4'hF); tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h8000_0000 + 32'(i) * 4, 0, 32'd0, 4'h0); tick();
      if (i >= 2) begin
        chk("t5_valid", 32'(rv[1]), 32'd1);
        chk("t5_rdata", rd[1], 32'hA500_0000 + 32'(i - 2));
      end
    end
    idle(); tick();
    chk("t5_rdata", rd[1], 32'hA500_0002);
    tick();
    chk("t5_rdata", rd[1], 32'hA500_0003);
    tick();
    chk("t5_tail", 32'(rv[1]), 32'd0);

    // Reset with two responses in flight
    drive(1, 32'h8000_0000, 0, 32'd0, 4'h0); tick(); tick();
    do_reset();
    chk("t6_gnt",    32'(gnt[1]), 32'd1);
    chk("t6_errcnt", 32'(ec[1]),  32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_noresp", 32'(rv[1]), 32'd0);
    end
    drive(1, 32'h8000_0000, 0, 32'd0, 4'h0); tick();
    idle(); tick(); tick();
    chk("t6_valid", 32'(rv[1]), 32'd1);
    chk("t6_rdata", rd[1], 32'd0);
    tick();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0:       a = 32'h7FFF_FFFC;
        1:       a = 32'h8000_0400 + 32'($urandom_range(0, 3));
        2:       a = $urandom();
        3:       a = 32'h8000_03FC + 32'($urandom_range(0, 3));
        default: a = 32'h8000_0000 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      endcase
      drive($urandom_range(0, 9) < 7, a, 1'($urandom_range(0, 1)), $urandom(),
            4'($urandom_range(0, 15)));
      tick();
    end

    // Error counter saturation
    drive(1, 32'h7FFF_FFFC, 0, 32'd0, 4'h0);
    for (int n = 0; n < 270; n++) tick();
    idle(); tick(); tick();
    chk("sat_errcnt", 32'(ec[0]), 32'd255);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
